// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS pipeline control blocks.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  // Forward-select encoding: 0 = register file, k+1 = result of stage k.
  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

endpackage

// File: rtl/hazard_match_prio.sv
// Picks the youngest (lowest-index) matching in-flight stage for one operand
// and reports whether that producer is a load.
module hazard_match_prio
  import mips_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [DEPTH-1:0] ld_i,
  output logic             hit_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             ld_o
);

  // Scan oldest to youngest so the youngest match is the last to win.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    ld_o  = 1'b0;
    for (int k = DEPTH - 1; k >= STG_EX; k--) begin
      if (match_i[k]) begin
        hit_o = 1'b1;
        idx_o = SEL_W'(k);
        ld_o  = ld_i[k];
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control: scoreboard of in-flight writers
// behind ID, forwarding selects, stall/flush requests and a stall counter.
module hazard_fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_AW   = mips_pkg::REG_AW,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              br_taken,
  input  logic              fwd_mode,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic              id_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  localparam logic [SEL_W-1:0] LOAD_LAT_S = SEL_W'(LOAD_LAT);
  localparam logic [SEL_W-1:0] SEL_RF     = SEL_W'(FWD_RF);

  logic [DEPTH-1:0]             v_q, v_d, ld_q, ld_d;
  logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [DEPTH-1:0] m_a, m_b;
  logic             hit_a, hit_b, ld_a, ld_b;
  logic [SEL_W-1:0] idx_a, idx_b;
  logic             lu_a, lu_b, stall_raw, new_v;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      m_a[k] = v_q[k] && (dst_q[k] == id_src1) && (id_src1 != '0);
      m_b[k] = v_q[k] && (dst_q[k] == id_src2) && (id_src2 != '0) && id_src2_used;
    end
  end

  hazard_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_prio_a (
    .match_i (m_a),
    .ld_i    (ld_q),
    .hit_o   (hit_a),
    .idx_o   (idx_a),
    .ld_o    (ld_a)
  );

  hazard_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_prio_b (
    .match_i (m_b),
    .ld_i    (ld_q),
    .hit_o   (hit_b),
    .idx_o   (idx_b),
    .ld_o    (ld_b)
  );

  // A load whose data is not yet forwardable forces a bubble instead of a select.
  assign lu_a = hit_a && ld_a && (idx_a < LOAD_LAT_S);
  assign lu_b = hit_b && ld_b && (idx_b < LOAD_LAT_S);

  always_comb begin
    stall_raw = 1'b0;
    fwd_sel_a = SEL_RF;
    fwd_sel_b = SEL_RF;
    if (id_valid) begin
      if (fwd_mode) begin
        stall_raw = lu_a || lu_b;
        if (hit_a && !lu_a) fwd_sel_a = idx_a + SEL_W'(1);
        if (hit_b && !lu_b) fwd_sel_b = idx_b + SEL_W'(1);
      end else begin
        stall_raw = (|m_a) || (|m_b);
      end
    end
  end

  assign stall    = stall_raw && !br_taken;
  assign id_flush = br_taken;

  assign new_v = id_valid && id_wb_en && (id_dest != '0) && !stall && !br_taken;

  always_comb begin
    v_d[0]   = new_v;
    dst_d[0] = new_v ? id_dest : '0;
    ld_d[0]  = new_v && id_mem_read;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      dst_d[k] = dst_q[k-1];
      ld_d[k]  = ld_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                   cnt_d = '0;
    else if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      dst_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: in-flight instruction model checked every cycle,
// plus directed sequences with literal expectations.
module tb_hazard_fwd_unit;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_src2_used, id_wb_en, id_mem_read, br_taken, fwd_mode, clr_cnt;
  logic [4:0] id_src1, id_src2, id_dest;
  logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
  logic       stall, flush, stall2, flush2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  hazard_fwd_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .br_taken(br_taken), .fwd_mode(fwd_mode),
    .fwd_sel_a(sel_a), .fwd_sel_b(sel_b), .stall(stall), .id_flush(flush),
    .stall_cnt(cnt), .clr_cnt(clr_cnt)
  );

  hazard_fwd_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .br_taken(br_taken), .fwd_mode(fwd_mode),
    .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2), .stall(stall2), .id_flush(flush2),
    .stall_cnt(cnt2), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  // In-flight writers by age: pipe[0] is the instruction now in EX.
  typedef struct {
    bit v;
    int dst;
    bit ld;
  } ent_t;

  ent_t pipe [DEPTH];
  int   m_cnt, m_cnt2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(output bit st, output int sa, output int sb);
    int ka, kb;
    ka = -1; kb = -1; st = 0; sa = 0; sb = 0;
    if (id_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ka < 0 && pipe[k].v && pipe[k].dst == int'(id_src1) && id_src1 != 0) ka = k;
        if (kb < 0 && id_src2_used && pipe[k].v && pipe[k].dst == int'(id_src2) && id_src2 != 0) kb = k;
      end
      if (!fwd_mode) begin
        st = (ka >= 0) || (kb >= 0);
      end else begin
        if (ka >= 0) begin
          if (pipe[ka].ld && ka < LOAD_LAT) st = 1; else sa = ka + 1;
        end
        if (kb >= 0) begin
          if (pipe[kb].ld && kb < LOAD_LAT) st = 1; else sb = kb + 1;
        end
      end
    end
    if (br_taken) st = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit st;
    int sa, sb;
    bit nv;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '{0, 0, 0};
      m_cnt  <= 0;
      m_cnt2 <= 0;
    end else begin
      model_eval(st, sa, sb);
      nv = id_valid && id_wb_en && id_dest != 0 && !st && !br_taken;
      pipe[0] <= '{nv, nv ? int'(id_dest) : 0, nv && id_mem_read};
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
      m_cnt  <= clr_cnt ? 0 : (st && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_cnt2 <= clr_cnt ? 0 : (st && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
    end
  end

  always @(negedge clk) begin
    bit st;
    int sa, sb;
    if (chk_on) begin
      model_eval(st, sa, sb);
      chk("m_stall", stall, st);
      chk("m_flush", flush, br_taken);
      chk("m_sel_a", sel_a, sa);
      chk("m_sel_b", sel_b, sb);
      chk("m_cnt", cnt, m_cnt);
      chk("m_stall_sat", stall2, st);
      chk("m_cnt_sat", cnt2, m_cnt2);
    end
  end

  task automatic drv(input bit v, input int s1, input int s2, input bit s2u, input int d,
                     input bit wb, input bit mr, input bit br, input bit md, input bit clr);
    id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_src2_used = s2u;
    id_dest = 5'(d); id_wb_en = wb; id_mem_read = mr; br_taken = br;
    fwd_mode = md; clr_cnt = clr;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit md);
    drv(0, 0, 0, 0, 0, 0, 0, 0, md, 0);
    repeat (DEPTH) go();
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Reset / idle
    drv(1, 3, 4, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("t1_stall", stall, 0); chk("t1_sel_a", sel_a, 0);
    chk("t1_sel_b", sel_b, 0); chk("t1_cnt", cnt, 0);
    go();

    // Back-to-back ALU RAW walks the select through EX, MEM, WB
    drv(1, 0, 0, 0, 5, 1, 0, 0, 1, 0); go();
    drv(1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t2_sel_ex", sel_a, 1); go();
    @(negedge clk); chk("t2_sel_mem", sel_a, 2); go();
    @(negedge clk); chk("t2_sel_wb", sel_a, 3); go();
    @(negedge clk); chk("t2_sel_rf", sel_a, 0); go();

    // Load-use on operand B
    drv(1, 0, 0, 1, 8, 1, 1, 0, 1, 0); go();
    drv(1, 0, 8, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t3_stall", stall, 1); chk("t3_sel_b0", sel_b, 0); go();
    @(negedge clk); chk("t3_nostall", stall, 0); chk("t3_sel_b2", sel_b, 2);
    chk("t3_cnt", cnt, 1); go();
    drain(1);

    // Stall-only mode
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); go();
    drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0); go();
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); chk("t4_stall", stall, 1); go();
    end
    @(negedge clk); chk("t4_release", stall, 0); chk("t4_cnt", cnt, 3);
    chk("t4_cnt_sat", cnt2, 3); go();

    // Youngest-stage priority, r0 and unused rt
    drv(1, 0, 0, 0, 6, 1, 0, 0, 1, 0); go(); go();
    drv(1, 6, 0, 0, 0, 1, 0, 0, 1, 0);
    @(negedge clk); chk("t5_prio", sel_a, 1); chk("t5_prio_stall", stall, 0); go();
    drv(1, 0, 6, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t5_r0_a", sel_a, 0); chk("t5_unused_b", sel_b, 0);
    chk("t5_r0_stall", stall, 0); go();
    drv(1, 0, 6, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t5_used_b", sel_b, 3); go();
    drain(1);

    // Taken branch beats load-use stall; wrong-path writer becomes a bubble
    drv(1, 0, 0, 0, 8, 1, 1, 0, 1, 0); go();
    drv(1, 0, 8, 1, 9, 1, 0, 1, 1, 0);
    @(negedge clk); chk("t6_flush", flush, 1); chk("t6_stall", stall, 0);
    chk("t6_sel_b", sel_b, 0); go();
    drv(1, 9, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t6_bubble", sel_a, 0); chk("t6_noflush", flush, 0); go();
    drain(0);

    // Saturation of the 2-bit counter over 5 stall cycles
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); go();
    drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0); go();
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) go();
    drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0); go();
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) go();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t6_cnt5", cnt, 5); chk("t6_cnt_sat", cnt2, 3);
    go(); go();

    // Clear wins over increment, then async reset mid-stall
    drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0); go();
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("t7_stall", stall, 1); go();
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t7_clr", cnt, 0); chk("t7_clr_sat", cnt2, 0); go();
    @(negedge clk); chk("t7_cnt1", cnt, 1); chk("t7_stall3", stall, 1);
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_stall", stall, 0); chk("t8_rst_cnt", cnt, 0);
    chk("t8_rst_sel", sel_a, 0); chk("t8_rst_flush", flush, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t8_after_stall", stall, 0);
    go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
